// File: rtl/noc_enc_scheduler_pkg.sv
// Shared types and sizing for the NoC encoder scheduler: FSM states, packet layout
// and the layer configuration legality rule.
package noc_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned NUM_COL    = 4;
    localparam int unsigned NUM_ROW    = 4;
    localparam int unsigned COL_W      = $clog2(NUM_COL);
    localparam int unsigned ROW_W      = $clog2(NUM_ROW);
    localparam int unsigned PKT_W      = ROW_W + COL_W + 2 * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, CHECK, STREAM, DRAIN, ERR} sched_state_t;

    typedef struct packed {
        logic [ROW_W-1:0]        row;
        logic [COL_W-1:0]        col;
        logic [2*DATA_WIDTH-1:0] data;
    } noc_pkt_t;

    // The kernel window must fit inside the PE array and at least one channel is needed.
    function automatic logic cfg_illegal(logic [7:0] k, logic [7:0] nch);
        return (k == 8'd0) || (k > 8'(NUM_ROW)) || (k > 8'(NUM_COL)) || (nch == 8'd0);
    endfunction

endpackage

// File: rtl/noc_enc_scheduler_if.sv
// FIFO read side and NoC injection port of the encoder scheduler.
interface noc_enc_scheduler_if;
    import noc_pkg::*;

    logic [2*DATA_WIDTH-1:0] fifo_dout;
    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic                    pkt_valid;
    logic                    pkt_ready;
    logic [ROW_W-1:0]        pkt_row;
    logic [COL_W-1:0]        pkt_col;
    logic [2*DATA_WIDTH-1:0] pkt_data;

    modport master (
        input  fifo_dout, fifo_empty, pkt_ready,
        output fifo_rd_en, pkt_valid, pkt_row, pkt_col, pkt_data
    );

    modport slave (
        output fifo_dout, fifo_empty, pkt_ready,
        input  fifo_rd_en, pkt_valid, pkt_row, pkt_col, pkt_data
    );

endinterface

// File: rtl/noc_enc_scheduler_pkt_reg.sv
// One-entry valid/ready output register; data is held while valid and not accepted.
module noc_pkt_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [Width-1:0] out_data,
    output logic             can_load
);

    // Reload is allowed in the same cycle the held entry is accepted.
    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/noc_enc_scheduler.sv
// Layer sequencer: pops k*k*num_channel FIFO words, tags each with its PE (row,col)
// and injects them into the NoC through a single output register.
module noc_enc_scheduler
    import noc_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 kernel_size,
    input  logic [7:0]                 num_channel,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err,
    noc_enc_scheduler_if.master        bus
);

    sched_state_t     state;
    logic [7:0]       k_q;
    logic [7:0]       nch_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [7:0]       ch_q;
    logic [15:0]      word_q;
    logic [15:0]      total_q;

    logic     pop;
    logic     can_load;
    logic     pkt_valid;
    logic     col_wrap;
    logic     row_wrap;
    logic     ch_wrap;
    logic     last_word;
    noc_pkt_t pkt_in;
    noc_pkt_t pkt_out;

    // Gated by rst so an aborting reset never consumes a word.
    assign pop       = (state == STREAM) && !bus.fifo_empty && can_load && !rst;
    assign col_wrap  = 8'(col_q) == (k_q - 8'd1);
    assign row_wrap  = 8'(row_q) == (k_q - 8'd1);
    assign ch_wrap   = ch_q == (nch_q - 8'd1);
    assign last_word = word_q == (total_q - 16'd1);
    assign pkt_in    = '{row: row_q, col: col_q, data: bus.fifo_dout};

    noc_pkt_reg #(
        .Width (PKT_W)
    ) u_pkt_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (pop),
        .in_data   (pkt_in),
        .out_ready (bus.pkt_ready),
        .out_valid (pkt_valid),
        .out_data  (pkt_out),
        .can_load  (can_load)
    );

    assign bus.fifo_rd_en = pop;
    assign bus.pkt_valid  = pkt_valid;
    assign bus.pkt_row    = pkt_out.row;
    assign bus.pkt_col    = pkt_out.col;
    assign bus.pkt_data   = pkt_out.data;
    assign busy           = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            k_q     <= '0;
            nch_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ch_q    <= '0;
            word_q  <= '0;
            total_q <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        k_q     <= kernel_size;
                        nch_q   <= num_channel;
                        cfg_err <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    row_q   <= '0;
                    col_q   <= '0;
                    ch_q    <= '0;
                    word_q  <= '0;
                    total_q <= 16'(k_q) * 16'(k_q) * 16'(nch_q);
                    state   <= cfg_illegal(k_q, nch_q) ? ERR : STREAM;
                end
                STREAM: begin
                    if (pop) begin
                        word_q <= word_q + 16'd1;
                        if (col_wrap) begin
                            col_q <= '0;
                            if (row_wrap) begin
                                row_q <= '0;
                                ch_q  <= ch_wrap ? 8'd0 : ch_q + 8'd1;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if (last_word) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pkt_valid && bus.pkt_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                ERR: begin
                    state   <= IDLE;
                    done    <= 1'b1;
                    cfg_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
